// File: rtl/silife_step_scheduler.sv
// Generation step scheduler for the silife matrix: a small Wishbone register block that issues
// single-cycle step pulses, free-running or on command, and holds them off while the cell port is busy.
module silife_step_scheduler #(
  parameter int PERIOD_BITS = 24,
  parameter int GEN_BITS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  input  logic        cell_busy,
  output logic        step,
  output logic        running
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_GEN    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  logic                   run_q, run_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [GEN_BITS-1:0]    gen_q, gen_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic                   step_q, step_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   accept;
  logic                   wrEn;
  logic                   wrCtrl;
  logic                   wrPeriod;
  logic                   wrStatus;
  logic                   stepOnce;
  logic                   clearGen;
  logic [PERIOD_BITS-1:0] periodLast;
  logic                   tick;
  logic                   request;
  logic                   consume;
  logic                   unusedBits;

  assign accept   = i_wb_cyc && i_wb_stb && !ack_q;
  assign wrEn     = accept && i_wb_we;
  assign wrCtrl   = wrEn && (i_wb_addr[3:2] == ADDR_CTRL);
  assign wrPeriod = wrEn && (i_wb_addr[3:2] == ADDR_PERIOD);
  assign wrStatus = wrEn && (i_wb_addr[3:2] == ADDR_STATUS);
  assign stepOnce = wrCtrl && i_wb_data[1];
  assign clearGen = wrCtrl && i_wb_data[2];

  // A period of zero behaves like a period of one: the counter ticks every cycle.
  assign periodLast = (period_q == '0) ? '0 : period_q - PERIOD_BITS'(1);
  assign tick       = run_q && (cnt_q >= periodLast);
  assign request    = tick || stepOnce;
  // A step already on the wire blocks the next one, so pulses are never adjacent.
  assign consume    = pending_q && !cell_busy && !step_q;

  assign unusedBits = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_data};

  always_comb begin
    run_d     = run_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    gen_d     = gen_q;
    overrun_d = overrun_q;
    rdata_d   = '0;

    if (wrCtrl) run_d = i_wb_data[0];
    if (wrPeriod) period_d = i_wb_data[PERIOD_BITS-1:0];

    if (wrPeriod || !run_q || tick) cnt_d = '0;
    else cnt_d = cnt_q + PERIOD_BITS'(1);

    pending_d = (pending_q && !consume) || request;
    step_d    = consume;

    if (wrStatus && i_wb_data[2]) overrun_d = 1'b0;
    if (request && pending_q && !consume) overrun_d = 1'b1;

    // Clearing the generation count beats a step issued on the same edge.
    if (clearGen) gen_d = '0;
    else if (consume) gen_d = gen_q + GEN_BITS'(1);

    ack_d = accept;
    if (accept && !i_wb_we) begin
      case (i_wb_addr[3:2])
        ADDR_CTRL:   rdata_d = {31'd0, run_q};
        ADDR_PERIOD: rdata_d = 32'(period_q);
        ADDR_GEN:    rdata_d = 32'(gen_q);
        default:     rdata_d = {29'd0, overrun_q, pending_q, run_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= 1'b0;
      period_q  <= PERIOD_BITS'(1);
      cnt_q     <= '0;
      gen_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      step_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      run_q     <= run_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      gen_q     <= gen_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      step_q    <= step_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_data = rdata_q;
  assign step      = step_q;
  assign running   = run_q;

endmodule

// File: tb/tb_silife_step_scheduler.sv
// Bench for silife_step_scheduler: a default build and a 4-bit generation build share one bus,
// checked every cycle against a cycle-level model plus directed literal expectations.
module tb_silife_step_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_wb_cyc, i_wb_stb, i_wb_we, cell_busy;
  logic [31:0] i_wb_addr, i_wb_data;
  logic        o_wb_ack, step, running;
  logic [31:0] o_wb_data;
  logic        ack4, step4, running4;
  logic [31:0] data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  silife_step_scheduler dut (
    .clk(clk), .reset(reset), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .cell_busy(cell_busy), .step(step), .running(running)
  );

  silife_step_scheduler #(.GEN_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(ack4), .o_wb_data(data4),
    .cell_busy(cell_busy), .step(step4), .running(running4)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state: the timer is a run-phase count whose residue modulo the period marks ticks.
  logic        mRun, mAck, mStep, mPend, mOvr;
  logic [23:0] mPeriod;
  logic [31:0] mGen, mRdata, mRdata4;
  longint      mPhase;
  bit          modelValid = 1'b0;

  always @(posedge clk) begin : model
    logic       acc, wr, tick, once, stepNow, setOvr;
    logic [1:0] sel;
    longint     effP;
    if (reset) begin
      mRun = 1'b0; mPeriod = 24'd1; mGen = 32'd0; mPhase = 0; mPend = 1'b0;
      mOvr = 1'b0; mStep = 1'b0; mAck = 1'b0; mRdata = 32'd0; mRdata4 = 32'd0;
    end else begin
      sel     = i_wb_addr[3:2];
      acc     = i_wb_cyc && i_wb_stb && !mAck;
      wr      = acc && i_wb_we;
      effP    = (mPeriod == 24'd0) ? 1 : longint'(mPeriod);
      tick    = mRun && ((mPhase % effP) == effP - 1);
      once    = wr && (sel == 2'd0) && i_wb_data[1];
      stepNow = mPend && !cell_busy && !mStep;
      setOvr  = (tick || once) && mPend && !stepNow;
      mRdata  = 32'd0;
      mRdata4 = 32'd0;
      if (acc && !i_wb_we) begin
        case (sel)
          2'd0:    mRdata = {31'd0, mRun};
          2'd1:    mRdata = {8'd0, mPeriod};
          2'd2:    mRdata = mGen;
          default: mRdata = {29'd0, mOvr, mPend, mRun};
        endcase
        mRdata4 = (sel == 2'd2) ? {28'd0, mGen[3:0]} : mRdata;
      end
      mAck = acc;
      if (wr && (sel == 2'd0) && i_wb_data[2]) mGen = 32'd0;
      else if (stepNow) mGen = mGen + 32'd1;
      if (setOvr) mOvr = 1'b1;
      else if (wr && (sel == 2'd3) && i_wb_data[2]) mOvr = 1'b0;
      mPend  = (mPend && !stepNow) || tick || once;
      mPhase = ((wr && (sel == 2'd1)) || !mRun) ? 0 : mPhase + 1;
      if (wr && (sel == 2'd0)) mRun = i_wb_data[0];
      if (wr && (sel == 2'd1)) mPeriod = i_wb_data[23:0];
      mStep = stepNow;
    end
    modelValid = 1'b1;
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("step", 32'(step), 32'(mStep));
      checkOutput("running", 32'(running), 32'(mRun));
      checkOutput("ack", 32'(o_wb_ack), 32'(mAck));
      checkOutput("rdata", o_wb_data, mRdata);
      checkOutput("step4", 32'(step4), 32'(mStep));
      checkOutput("running4", 32'(running4), 32'(mRun));
      checkOutput("ack4", 32'(ack4), 32'(mAck));
      checkOutput("rdata4", data4, mRdata4);
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] regSel, input logic [31:0] data,
                               input logic busy, output logic [31:0] rd, output logic [31:0] rd4);
    @(negedge clk);
    i_wb_cyc  = 1'b1;
    i_wb_stb  = 1'b1;
    i_wb_we   = we;
    i_wb_addr = {28'd0, regSel, 2'b00};
    i_wb_data = data;
    cell_busy = busy;
    @(negedge clk);
    checkOutput("ackNextCycle", 32'(o_wb_ack), 32'd1);
    rd  = o_wb_data;
    rd4 = data4;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic watchSteps(input int cycles, input int expGap, output int count, output int firstAt);
    int last;
    last = -1;
    count = 0;
    firstAt = -1;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (step) begin
        if (last >= 0 && expGap > 0) checkOutput("stepGap", 32'(i - last), 32'(expGap));
        if (firstAt < 0) firstAt = i;
        last = i;
        count++;
      end
    end
  endtask

  logic [31:0] rd, rd4;
  int          cnt, first;

  initial begin
    reset = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = 32'd0; i_wb_data = 32'd0; cell_busy = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b0, 2'd0, 32'd0, 1'b0, rd, rd4); checkOutput("resetCtrl", rd, 32'd0);
    applyStimulus(1'b0, 2'd1, 32'd0, 1'b0, rd, rd4); checkOutput("resetPeriod", rd, 32'd1);
    applyStimulus(1'b0, 2'd2, 32'd0, 1'b0, rd, rd4); checkOutput("resetGen", rd, 32'd0);
    applyStimulus(1'b0, 2'd3, 32'd0, 1'b0, rd, rd4); checkOutput("resetStatus", rd, 32'd0);

    // Free-running at period 4.
    applyStimulus(1'b1, 2'd1, 32'd4, 1'b0, rd, rd4);
    applyStimulus(1'b1, 2'd0, 32'd1, 1'b0, rd, rd4);
    watchSteps(40, 4, cnt, first);
    checkOutput("period4Count", 32'(cnt), 32'd9);
    checkOutput("period4First", 32'(first), 32'd5);
    applyStimulus(1'b0, 2'd2, 32'd0, 1'b0, rd, rd4); checkOutput("period4Gen", rd, 32'd10);
    applyStimulus(1'b0, 2'd3, 32'd0, 1'b0, rd, rd4); checkOutput("statusRunning", rd & 32'd1, 32'd1);
    applyStimulus(1'b1, 2'd0, 32'd0, 1'b0, rd, rd4);
    repeat (8) @(negedge clk);

    // One-shot step with the timer stopped.
    applyStimulus(1'b1, 2'd0, 32'd4, 1'b0, rd, rd4);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 2'd2, 32'd0, 1'b0, rd, rd4); checkOutput("clearedGen", rd, 32'd0);
    applyStimulus(1'b1, 2'd0, 32'd2, 1'b0, rd, rd4);
    watchSteps(20, 0, cnt, first);
    checkOutput("onceCount", 32'(cnt), 32'd1);
    checkOutput("onceFirst", 32'(first), 32'd1);
    applyStimulus(1'b0, 2'd2, 32'd0, 1'b0, rd, rd4); checkOutput("onceGen", rd, 32'd1);

    // Busy deferral and overrun at period 2.
    applyStimulus(1'b1, 2'd1, 32'd2, 1'b0, rd, rd4);
    applyStimulus(1'b1, 2'd0, 32'd1, 1'b1, rd, rd4);
    watchSteps(10, 0, cnt, first);
    checkOutput("busyNoStep", 32'(cnt), 32'd0);
    applyStimulus(1'b0, 2'd3, 32'd0, 1'b1, rd, rd4); checkOutput("busyStatus", rd, 32'd7);
    @(negedge clk);
    cell_busy = 1'b0;
    @(negedge clk);
    checkOutput("stepAfterBusy", 32'(step), 32'd1);
    repeat (6) @(negedge clk);
    applyStimulus(1'b1, 2'd3, 32'd4, 1'b0, rd, rd4);
    applyStimulus(1'b0, 2'd3, 32'd0, 1'b0, rd, rd4); checkOutput("overrunCleared", (rd >> 2) & 32'd1, 32'd0);
    applyStimulus(1'b1, 2'd0, 32'd0, 1'b0, rd, rd4);
    repeat (6) @(negedge clk);

    // Period 0 behaves as period 1, limited to a step every other cycle.
    applyStimulus(1'b1, 2'd1, 32'd0, 1'b0, rd, rd4);
    applyStimulus(1'b1, 2'd0, 32'd1, 1'b0, rd, rd4);
    watchSteps(20, 2, cnt, first);
    checkOutput("period0Count", 32'(cnt), 32'd10);
    checkOutput("period0First", 32'(first), 32'd2);
    applyStimulus(1'b1, 2'd0, 32'd0, 1'b0, rd, rd4);
    repeat (6) @(negedge clk);
    checkOutput("stoppedRunning", 32'(running), 32'd0);

    // clear_gen lands on the same edge the held step is released.
    applyStimulus(1'b1, 2'd0, 32'd2, 1'b1, rd, rd4);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 2'd0, 32'd4, 1'b0, rd, rd4);
    checkOutput("stepWithClear", 32'(step), 32'd1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 2'd2, 32'd0, 1'b0, rd, rd4); checkOutput("clearWinsGen", rd, 32'd0);

    // Reset in the middle of a run.
    applyStimulus(1'b1, 2'd1, 32'd1, 1'b0, rd, rd4);
    applyStimulus(1'b1, 2'd0, 32'd1, 1'b0, rd, rd4);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("resetStep", 32'(step), 32'd0);
    checkOutput("resetRunning", 32'(running), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 2'd2, 32'd0, 1'b0, rd, rd4); checkOutput("midResetGen", rd, 32'd0);

    // Generation wrap on the 4-bit build.
    for (int k = 0; k < 17; k++) applyStimulus(1'b1, 2'd0, 32'd2, 1'b0, rd, rd4);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 2'd2, 32'd0, 1'b0, rd, rd4);
    checkOutput("gen17", rd, 32'd17);
    checkOutput("gen4Wrap", rd4, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
